inst_fetch: RTL and testbench

//  Fetch stage producing the instruction stream consumed by the decode stage (instrD/pcD).

---
 rtl/inst_fetch_if.sv | 32 +++
 rtl/inst_fetch.sv | 212 +++++++++++++++++++++
 tb/tb_inst_fetch.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_if
//   SRAM-like instruction bus between the fetch stage (master) and the
//   instruction memory (slave). At most one request is outstanding at a time.
//
//   inst_req      master -> slave  request valid
//   inst_wr       master -> slave  write enable (fetch only reads: always 0)
//   inst_size     master -> slave  access size (2'b10 = word)
//   inst_addr     master -> slave  request address
//   inst_addr_ok  slave  -> master request accepted this cycle
//   inst_data_ok  slave  -> master read data valid this cycle
//   inst_rdata    slave  -> master read data
// -----------------------------------------------------------------------------
interface inst_fetch_if;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req, inst_wr, inst_size, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata
  );

  modport slave (
    input  inst_req, inst_wr, inst_size, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata
  );
endinterface

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
//   Fetch stage feeding the decode stage. Owns the PC, issues one word read at a
//   time on the instruction bus, and presents each returned word with its
//   address in a registered output slot. A one-entry skid parks a response that
//   arrives while decode is stalled. A redirect restarts fetch at a new address
//   and discards any response still in flight. A misaligned PC produces a single
//   NOP with adel_f_o set, after which fetch waits for the next redirect.
//
//   clk            clock, all state updates on the rising edge
//   rst            synchronous reset, active high
//   bus            instruction bus (master side)
//   stall_d_i      decode cannot accept; the output slot holds its contents
//   redirect_i     one-cycle pulse: restart fetch at redirect_pc_i
//   redirect_pc_i  new fetch address
//   instr_d_o      instruction to decode
//   pc_d_o         address of instr_d_o
//   valid_d_o      instr_d_o / pc_d_o / adel_f_o are valid
//   adel_f_o       fetch address error for pc_d_o
// -----------------------------------------------------------------------------
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus,
  input  logic         stall_d_i,
  input  logic         redirect_i,
  input  logic [31:0]  redirect_pc_i,
  output logic [31:0]  instr_d_o,
  output logic [31:0]  pc_d_o,
  output logic         valid_d_o,
  output logic         adel_f_o
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,  // idle, ready to issue a request
    S_WAIT  = 2'd1,  // one request outstanding
    S_HOLD  = 2'd2,  // response parked in the skid entry
    S_FAULT = 2'd3   // misaligned PC reported, waiting for a redirect
  } state_e;

  state_e      state_q,     state_d;
  logic [31:0] pc_q,        pc_d;
  logic        discard_q,   discard_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q,   skid_pc_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q,    out_pc_d;
  logic        out_valid_q, out_valid_d;
  logic        out_adel_q,  out_adel_d;

  logic        req;
  logic        slot_free;
  logic        misaligned;
  logic [31:0] pc_prev;

  // The output slot can take a new entry when it is empty or being consumed.
  assign slot_free  = !out_valid_q || !stall_d_i;
  assign misaligned = (pc_q[1:0] != 2'b00);
  // pc_q advances on address acceptance, so the word returned in WAIT
  // belongs to the address one word behind it.
  assign pc_prev    = pc_q - 32'd4;

  // NOTE: every signal driven here gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    discard_d    = discard_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    out_valid_d  = out_valid_q;
    out_adel_d   = out_adel_q;
    req          = 1'b0;

    // A consumed slot empties unless something is loaded below.
    if (slot_free) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      S_REQ: begin
        if (misaligned) begin
          if (slot_free) begin
            out_instr_d = NOP_INSTR;
            out_pc_d    = pc_q;
            out_adel_d  = 1'b1;
            out_valid_d = 1'b1;
            state_d     = S_FAULT;
          end
        end else begin
          req = 1'b1;
          if (bus.inst_addr_ok) begin
            pc_d    = pc_q + 32'd4;
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (bus.inst_data_ok) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else if (slot_free) begin
            out_instr_d = bus.inst_rdata;
            out_pc_d    = pc_prev;
            out_adel_d  = 1'b0;
            out_valid_d = 1'b1;
            state_d     = S_REQ;
          end else begin
            skid_instr_d = bus.inst_rdata;
            skid_pc_d    = pc_prev;
            state_d      = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (slot_free) begin
          out_instr_d = skid_instr_q;
          out_pc_d    = skid_pc_q;
          out_adel_d  = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_REQ;
        end
      end

      S_FAULT: begin
        // Only a redirect leaves this state.
      end

      default: begin
        state_d = S_REQ;
      end
    endcase

    // Redirect overrides everything above. A request accepted in the same
    // cycle, or one still outstanding, must have its response dropped.
    if (redirect_i) begin
      pc_d        = redirect_pc_i;
      out_valid_d = 1'b0;
      out_adel_d  = 1'b0;
      case (state_q)
        S_REQ: begin
          if (req && bus.inst_addr_ok) begin
            discard_d = 1'b1;
            state_d   = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (bus.inst_data_ok) begin
            discard_d = 1'b0;
            state_d   = S_REQ;
          end else begin
            discard_d = 1'b1;
            state_d   = S_WAIT;
          end
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its _d value from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      discard_q   <= 1'b0;
      out_instr_q <= 32'd0;
      out_pc_q    <= 32'd0;
      out_valid_q <= 1'b0;
      out_adel_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      discard_q   <= discard_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      out_valid_q <= out_valid_d;
      out_adel_q  <= out_adel_d;
    end
  end

  // NOTE: the skid payload is not reset; it is only read in HOLD, which is
  // entered only after both fields have been written.
  always_ff @(posedge clk) begin
    skid_instr_q <= skid_instr_d;
    skid_pc_q    <= skid_pc_d;
  end

  assign bus.inst_req  = req && !rst;
  assign bus.inst_wr   = 1'b0;
  assign bus.inst_size = 2'b10;
  assign bus.inst_addr = pc_q;

  assign instr_d_o = out_instr_q;
  assign pc_d_o    = out_pc_q;
  assign valid_d_o = out_valid_q;
  assign adel_f_o  = out_adel_q;

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
//   Random bus timing, decode stalls and redirects against a program-order
//   model: decode must see consecutive words starting at the last redirect
//   target (or the reset PC), each word equal to mem_word(address), and a
//   misaligned address must show up as a single NOP with adel set.
// -----------------------------------------------------------------------------
module tb_inst_fetch;
  localparam logic [31:0] RESET_PC  = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_d;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic        valid_d;
  logic        adel_f;

  always #5 clk = ~clk;

  inst_fetch_if bus ();

  inst_fetch #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .stall_d_i     (stall_d),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_d_o     (instr_d),
    .pc_d_o        (pc_d),
    .valid_d_o     (valid_d),
    .adel_f_o      (adel_f)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] req_pc;     // address the next bus request must carry
  logic [31:0] exp_pc;     // address of the next word decode must receive
  logic        fault_seen; // misaligned NOP already delivered
  logic        out_valid;  // a request is outstanding on the bus
  logic [31:0] out_addr;
  int unsigned out_cnt;
  int          cyc;
  int          last_acc;
  int          idle;
  int          acc_count;

  // Stimulus knobs
  int unsigned p_addr_ok;
  int unsigned max_delay;
  int unsigned p_stall;
  int unsigned p_redirect;
  logic        check_gap;
  logic        force_wrap;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    req_pc     = RESET_PC;
    exp_pc     = RESET_PC;
    fault_seen = 1'b0;
    out_valid  = 1'b0;
    out_addr   = 32'd0;
    out_cnt    = 0;
    last_acc   = -1;
    idle       = 0;
  endtask

  // Inputs for the coming cycle; called just after a rising edge.
  task automatic drive_inputs();
    bus.inst_addr_ok = ($urandom_range(99) < p_addr_ok);
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = $urandom;
    if (out_valid) begin
      if (out_cnt <= 1) begin
        bus.inst_data_ok = 1'b1;
        bus.inst_rdata   = mem_word(out_addr);
      end else begin
        out_cnt--;
      end
    end
    stall_d     = ($urandom_range(99) < p_stall);
    redirect    = 1'b0;
    redirect_pc = $urandom;
    if (force_wrap) begin
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      force_wrap  = 1'b0;
    end else if ($urandom_range(99) < p_redirect) begin
      redirect    = 1'b1;
      redirect_pc = 32'h8000_0000 | ($urandom & 32'h000F_FFFC);
      if ($urandom_range(4) == 0) redirect_pc[1:0] = 2'($urandom_range(3, 1));
    end
  endtask

  // One clock cycle: observe at the falling edge, update the model with what
  // the DUT sees this cycle, then drive the next cycle's inputs.
  task automatic step();
    logic acc_dec;
    @(negedge clk);
    cyc++;
    acc_dec = valid_d && !stall_d;

    if (fault_seen) begin
      check("fault_hold_valid", 32'(valid_d), 32'd0);
    end else if (acc_dec) begin
      if (exp_pc[1:0] != 2'b00) begin
        check("adel_flag",  32'(adel_f), 32'd1);
        check("adel_instr", instr_d, NOP_INSTR);
        check("adel_pc",    pc_d, exp_pc);
        fault_seen = 1'b1;
      end else begin
        check("pc_d",       pc_d, exp_pc);
        check("instr_d",    instr_d, mem_word(exp_pc));
        check("adel_clear", 32'(adel_f), 32'd0);
        exp_pc = exp_pc + 32'd4;
      end
      if (check_gap && last_acc >= 0) check("stream_gap", 32'(cyc - last_acc), 32'd2);
      last_acc = cyc;
      idle     = 0;
      acc_count++;
    end else begin
      idle++;
      if (idle > 80) begin
        check("progress_idle", 32'(idle), 32'd0);
        idle = 0;
      end
    end

    if (bus.inst_req) begin
      check("req_addr",        bus.inst_addr, req_pc);
      check("one_outstanding", 32'(out_valid), 32'd0);
    end
    if (req_pc[1:0] != 2'b00) check("misaligned_no_req", 32'(bus.inst_req), 32'd0);

    if (bus.inst_data_ok) out_valid = 1'b0;
    if (bus.inst_req && bus.inst_addr_ok) begin
      out_valid = 1'b1;
      out_addr  = bus.inst_addr;
      out_cnt   = $urandom_range(max_delay, 1);
      req_pc    = req_pc + 32'd4;
    end
    if (redirect) begin
      req_pc     = redirect_pc;
      exp_pc     = redirect_pc;
      fault_seen = 1'b0;
      idle       = 0;
      last_acc   = -1;
    end

    @(posedge clk);
    #1;
    drive_inputs();
  endtask

  initial begin
    rst              = 1'b1;
    stall_d          = 1'b0;
    redirect         = 1'b0;
    redirect_pc      = 32'd0;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = 32'd0;
    check_gap        = 1'b0;
    force_wrap       = 1'b0;
    cyc              = 0;
    acc_count        = 0;
    p_addr_ok        = 100;
    max_delay        = 1;
    p_stall          = 0;
    p_redirect       = 0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_valid",   32'(valid_d), 32'd0);
    check("rst_instr",   instr_d, 32'd0);
    check("rst_pc_d",    pc_d, 32'd0);
    check("rst_adel",    32'(adel_f), 32'd0);
    check("rst_req_low", 32'(bus.inst_req), 32'd0);
    check("inst_wr",     32'(bus.inst_wr), 32'd0);
    check("inst_size",   32'(bus.inst_size), 32'd2);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Streaming with a single-cycle bus: one word every second cycle,
    // first word valid two cycles after the first request.
    check_gap = 1'b1;
    drive_inputs();
    repeat (24) step();
    check("stream_count", 32'(acc_count), 32'd11);
    check_gap = 1'b0;

    // Random bus timing, stalls and redirects (including misaligned targets)
    p_addr_ok  = 60;
    max_delay  = 3;
    p_stall    = 30;
    p_redirect = 4;
    repeat (1500) step();
    force_wrap = 1'b1;  // redirect near the top of the address space
    repeat (1500) step();

    // Reset with a request outstanding, then a late data_ok that must be ignored
    for (int i = 0; i < 200 && !out_valid; i++) step();
    check("inflight_for_reset", 32'(out_valid), 32'd1);
    rst              = 1'b1;
    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    redirect         = 1'b0;
    stall_d          = 1'b0;
    @(negedge clk);
    check("rst_mid_req_low", 32'(bus.inst_req), 32'd0);
    @(posedge clk);
    #1;
    rst              = 1'b0;
    bus.inst_data_ok = 1'b1;
    bus.inst_rdata   = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rst_mid_valid",   32'(valid_d), 32'd0);
    check("rst_mid_req",     32'(bus.inst_req), 32'd1);
    check("rst_mid_addr",    bus.inst_addr, RESET_PC);
    @(posedge clk);
    #1;
    model_reset();
    drive_inputs();
    repeat (1000) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
